// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/status controller for a dual-clock FIFO: binary and gray
// write pointers, zero-lag full detection, fill level, almost-full and overflow.
module wptr_full_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int PTR_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [PTR_WIDTH-1:0]  wq2_rptr,
  input  logic [PTR_WIDTH-1:0]  afull_thresh,
  input  logic                  wovf_clr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH-1:0]  wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [PTR_WIDTH-1:0]  wlevel,
  output logic                  woverflow
);

  function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
    logic [PTR_WIDTH-1:0] b;
    b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_WIDTH-1:0] wbin_q, wbin_d;
  logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0] wlevel_q, wlevel_d;
  logic                 wfull_q, wfull_d;
  logic                 walmost_full_q, walmost_full_d;
  logic                 woverflow_q, woverflow_d;
  logic                 wen_s;
  logic [PTR_WIDTH-1:0] rbin_s;
  logic [PTR_WIDTH-1:0] full_cmp_s;

  // Next-state: everything is derived from the post-write pointer so full
  // asserts on the very edge of the filling write.
  always_comb begin
    wen_s          = winc & ~wfull_q & ~wrst;
    rbin_s         = gray2bin(wq2_rptr);
    full_cmp_s     = {~wq2_rptr[PTR_WIDTH-1:PTR_WIDTH-2], wq2_rptr[PTR_WIDTH-3:0]};
    wbin_d         = wbin_q + {{(PTR_WIDTH-1){1'b0}}, wen_s};
    wptr_d         = bin2gray(wbin_d);
    wlevel_d       = wbin_d - rbin_s;
    wfull_d        = (wptr_d == full_cmp_s);
    walmost_full_d = (wlevel_d >= afull_thresh);
    woverflow_d    = (winc & wfull_q) | (woverflow_q & ~wovf_clr);
  end

  // State registers with synchronous reset.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q         <= {PTR_WIDTH{1'b0}};
      wptr_q         <= {PTR_WIDTH{1'b0}};
      wlevel_q       <= {PTR_WIDTH{1'b0}};
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
    end
  end

  assign wen          = wen_s;
  assign waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl (ADDR_WIDTH=4): vector table applied
// through an expected-value queue, then a tracked wrap-around sequence.
module tb_wptr_full_ctrl;

  logic       wclk;
  logic       wrst;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic [4:0] afull_thresh;
  logic       wovf_clr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int errors = 0;
  int checks = 0;

  wptr_full_ctrl #(.ADDR_WIDTH(4)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr),
    .afull_thresh(afull_thresh), .wovf_clr(wovf_clr), .wen(wen),
    .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .woverflow(woverflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic       rst;
    logic       inc;
    logic [4:0] rq;
    logic [4:0] th;
    logic       clr;
    logic       e_wen;
    logic [3:0] e_waddr;
    logic [4:0] e_wptr;
    logic       e_full;
    logic       e_af;
    logic [4:0] e_lvl;
    logic       e_ovf;
  } vec_t;

  vec_t tv[$];
  vec_t sb[$];

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic vec_t mk(input logic rst, inc, input logic [4:0] rq, th,
                              input logic clr, e_wen, input logic [3:0] e_waddr,
                              input logic [4:0] e_wptr, input logic e_full, e_af,
                              input logic [4:0] e_lvl, input logic e_ovf);
    vec_t v;
    v.rst = rst; v.inc = inc; v.rq = rq; v.th = th; v.clr = clr;
    v.e_wen = e_wen; v.e_waddr = e_waddr; v.e_wptr = e_wptr; v.e_full = e_full;
    v.e_af = e_af; v.e_lvl = e_lvl; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Drive one vector, check the combinational enable, then check registered outputs after the edge.
  task automatic apply_vec(input vec_t v, input int idx);
    vec_t e;
    wrst = v.rst; winc = v.inc; wq2_rptr = v.rq; afull_thresh = v.th; wovf_clr = v.clr;
    sb.push_back(v);
    #1;
    chk("wen", idx, {31'd0, wen}, {31'd0, v.e_wen});
    @(posedge wclk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", idx, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("waddr", idx, {28'd0, waddr}, {28'd0, e.e_waddr});
      chk("wptr", idx, {27'd0, wptr}, {27'd0, e.e_wptr});
      chk("wfull", idx, {31'd0, wfull}, {31'd0, e.e_full});
      chk("walmost_full", idx, {31'd0, walmost_full}, {31'd0, e.e_af});
      chk("wlevel", idx, {27'd0, wlevel}, {27'd0, e.e_lvl});
      chk("woverflow", idx, {31'd0, woverflow}, {31'd0, e.e_ovf});
    end
  endtask

  initial begin
    logic [4:0] nb;
    logic [4:0] prev;
    logic [4:0] k5;

    wrst = 1'b1; winc = 1'b1; wq2_rptr = 5'd0; afull_thresh = 5'd14; wovf_clr = 1'b0;

    // Reset with winc held, then thresh=0 sets almost-full on the first edge.
    tv.push_back(mk(1'b1, 1'b1, 5'd0, 5'd14, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0));
    tv.push_back(mk(1'b1, 1'b1, 5'd0, 5'd14, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0));
    tv.push_back(mk(1'b0, 1'b0, 5'd0, 5'd0,  1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0));
    // Fill 16 entries against a stalled reader.
    for (int i = 0; i < 16; i++) begin
      k5 = 5'(i + 1);
      tv.push_back(mk(1'b0, 1'b1, 5'd0, 5'd14, 1'b0, 1'b1, k5[3:0], g(k5),
                      (i == 15), (i + 1 >= 14), k5, 1'b0));
    end
    // Overflow: three rejected writes, clear, then clear colliding with a set.
    tv.push_back(mk(1'b0, 1'b1, 5'd0, 5'd14, 1'b0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, 5'd0, 5'd14, 1'b0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, 5'd0, 5'd14, 1'b0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 5'd0, 5'd14, 1'b1, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0));
    tv.push_back(mk(1'b0, 1'b1, 5'd0, 5'd14, 1'b1, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1));
    // Release: reader at 1 then 4; overflow still sticky until cleared.
    tv.push_back(mk(1'b0, 1'b0, 5'b00001, 5'd14, 1'b0, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd15, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 5'b00110, 5'd14, 1'b0, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b0, 5'd12, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 5'b00110, 5'd14, 1'b1, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b0, 5'd12, 1'b0));
    // Refill to full across the upper half of the pointer space.
    tv.push_back(mk(1'b0, 1'b1, 5'b00110, 5'd14, 1'b0, 1'b1, 4'd1, 5'b11001, 1'b0, 1'b0, 5'd13, 1'b0));
    tv.push_back(mk(1'b0, 1'b1, 5'b00110, 5'd14, 1'b0, 1'b1, 4'd2, 5'b11011, 1'b0, 1'b1, 5'd14, 1'b0));
    tv.push_back(mk(1'b0, 1'b1, 5'b00110, 5'd14, 1'b0, 1'b1, 4'd3, 5'b11010, 1'b0, 1'b1, 5'd15, 1'b0));
    tv.push_back(mk(1'b0, 1'b1, 5'b00110, 5'd14, 1'b0, 1'b1, 4'd4, 5'b11110, 1'b1, 1'b1, 5'd16, 1'b0));
    // Same-cycle release: first write rejected, second accepted and refills.
    tv.push_back(mk(1'b0, 1'b1, 5'b00111, 5'd14, 1'b0, 1'b0, 4'd4, 5'b11110, 1'b0, 1'b1, 5'd15, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, 5'b00111, 5'd14, 1'b0, 1'b1, 4'd5, 5'b11111, 1'b1, 1'b1, 5'd16, 1'b1));
    // Mid-operation reset overrides winc and ignores the read pointer.
    tv.push_back(mk(1'b1, 1'b1, 5'b00111, 5'd14, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0));
    tv.push_back(mk(1'b1, 1'b1, 5'b00111, 5'd14, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0));

    for (int i = 0; i < tv.size(); i++) begin
      apply_vec(tv[i], i);
    end

    // Wrap: reader trails the writer by two entries for 100 writes.
    nb = 5'd0;
    prev = wptr;
    for (int k = 0; k < 100; k++) begin
      k5 = nb + 5'd1;
      apply_vec(mk(1'b0, 1'b1, g(nb - 5'd1), 5'd14, 1'b0, 1'b1, k5[3:0], g(k5),
                   1'b0, 1'b0, 5'd2, 1'b0), 100 + k);
      chk("wptr_one_bit_toggle", k, 32'($countones(prev ^ wptr)), 32'd1);
      prev = wptr;
      nb = k5;
    end

    chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
